hex_entry_buffer: RTL

//  Sits between the UART receiver and number_display. Consumes received bytes,

---
 rtl/hex_entry_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hex_entry_buffer.sv
// hex_entry_buffer
//   Sits between a UART receiver and a number display. Received ASCII hex
//   digits are shifted into a working register. A CR or LF commits the working
//   register to the displayed value num, so the display changes only on commit.
//   Editing bytes: BS drops the newest digit, ESC clears the entry. Any other
//   byte is rejected with an err pulse. A partial entry that stays idle for
//   TIMEOUT_CYC cycles is discarded.
//
// Parameters
//   DIGITS       number of hex digits held (1..7); num is 4*DIGITS bits wide
//   AUTO_COMMIT  1: commit as soon as DIGITS digits have been entered
//   TIMEOUT_CYC  idle cycles before a partial entry is discarded; 0 = never
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   rx_valid     1-cycle strobe; rx_data holds a received byte
//   rx_data      received byte
//   num          committed value; [3:0] holds the least significant digit
//   digit_count  digits currently in the working register, 0..DIGITS
//   busy         1 while an entry is in progress
//   commit       1-cycle pulse when num is updated
//   err          1-cycle pulse on an unrecognised byte
module hex_entry_buffer #(
  parameter int unsigned DIGITS      = 6,
  parameter bit          AUTO_COMMIT = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [4*DIGITS-1:0]   num,
  output logic [2:0]            digit_count,
  output logic                  busy,
  output logic                  commit,
  output logic                  err
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam logic [2:0]  MaxCount = 3'(DIGITS);
  localparam logic [31:0] TimerEnd = 32'(TIMEOUT_CYC - 1);

  typedef enum logic {StIdle, StEntry} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  working_q, working_d;
  logic [W-1:0]  num_q, num_d;
  logic [2:0]    count_q, count_d;
  logic [31:0]   timer_q, timer_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;

  // Byte classification
  logic       is_hex, is_eol, is_bs, is_esc;
  logic [3:0] nibble;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      is_hex = 1'b1;
      nibble = rx_data[3:0] + 4'd9;
    end
  end

  assign is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_bs  = (rx_data == 8'h08);
  assign is_esc = (rx_data == 8'h1B);

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == StEntry) && (timer_q == TimerEnd);

  always_comb begin
    state_d   = state_q;
    working_d = working_q;
    num_d     = num_q;
    count_d   = count_q;
    timer_d   = timer_q;
    commit_d  = 1'b0;
    err_d     = 1'b0;

    if (rx_valid) begin
      // A byte always wins over a coincident timeout.
      timer_d = '0;
      if (is_hex) begin
        // Shifting left drops the oldest digit once the register is full.
        working_d = (working_q << 4) | W'(nibble);
        if (count_q < MaxCount) begin
          count_d = count_q + 3'd1;
        end
        state_d = StEntry;
        if (AUTO_COMMIT && (count_d == MaxCount)) begin
          num_d     = working_d;
          commit_d  = 1'b1;
          working_d = '0;
          count_d   = '0;
          state_d   = StIdle;
        end
      end else if (is_eol) begin
        // Empty entry ignores terminators, so CR+LF commits only once.
        if (count_q != '0) begin
          num_d     = working_q;
          commit_d  = 1'b1;
          working_d = '0;
          count_d   = '0;
          state_d   = StIdle;
        end
      end else if (is_bs) begin
        if (count_q != '0) begin
          working_d = working_q >> 4;
          count_d   = count_q - 3'd1;
          if (count_q == 3'd1) begin
            state_d = StIdle;
          end
        end
      end else if (is_esc) begin
        working_d = '0;
        count_d   = '0;
        state_d   = StIdle;
      end else begin
        err_d = 1'b1;
      end
    end else if (timeout_hit) begin
      working_d = '0;
      count_d   = '0;
      timer_d   = '0;
      state_d   = StIdle;
    end else if (state_q == StEntry) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      working_q <= '0;
      num_q     <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      working_q <= working_d;
      num_q     <= num_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
    end
  end

  assign num         = num_q;
  assign digit_count = count_q;
  assign busy        = (state_q == StEntry);
  assign commit      = commit_q;
  assign err         = err_q;

endmodule
